// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: mul/div sequencer
// state encoding and default latency.
package hazard_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int MD_LATENCY_DEF = 32;
    localparam int MD_CNT_W       = 6;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute hazard inputs and pipeline-register controls exchanged
// between the pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
) ();

    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_md_start;
    logic             id_hilo_access;
    logic             ex_MemRead;
    logic [4:0]       ex_write_addr;
    logic             ex_branch_taken;

    logic             pc_wr_en;
    logic             if_id_wr_en;
    logic             if_id_flush;
    logic             id_ex_wr_en;
    logic             id_ex_flush;
    logic             md_go;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_jump,
               id_md_start, id_hilo_access, ex_MemRead, ex_write_addr,
               ex_branch_taken,
        input  pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush,
               md_go, md_busy, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_jump,
               id_md_start, id_hilo_access, ex_MemRead, ex_write_addr,
               ex_branch_taken,
        output pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush,
               md_go, md_busy, stall_cycles, flush_events
    );

endinterface

// File: rtl/hazard_ctrl_md_sequencer.sv
// Mul/div busy-interval sequencer: issues a one-cycle start pulse and holds
// busy until HI/LO becomes valid.
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic md_go_o,
    output logic md_busy_o
);

    localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 1);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;

    // State and countdown register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= MD_IDLE;
            md_cnt_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next-state and start pulse; busy covers the MD_LATENCY-1 cycles after md_go.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        md_go_o  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (reset && start_i) begin
                    md_go_o  = 1'b1;
                    state_d  = MD_BUSY;
                    md_cnt_d = CNT_LOAD;
                end else begin
                    md_cnt_d = 6'd0;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q <= 6'd1) begin
                    state_d  = MD_IDLE;
                    md_cnt_d = 6'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 6'd1;
                end
            end
            default: begin
                state_d  = MD_IDLE;
                md_cnt_d = 6'd0;
            end
        endcase
    end

    assign md_busy_o = reset & (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, HI/LO and redirect resolution driving
// PC / IF/ID / ID/EX enables and flushes, plus stall/flush perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    logic             lu_s, hl_s, stall_s, md_start_ok_s, md_go_s, md_busy_s;
    logic             flush_evt_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign lu_s = hz.ex_MemRead && (hz.ex_write_addr != 5'd0) &&
                  ((hz.id_uses_rs && (hz.id_rs_addr == hz.ex_write_addr)) ||
                   (hz.id_uses_rt && (hz.id_rt_addr == hz.ex_write_addr)));
    assign hl_s          = md_busy_s && (hz.id_hilo_access || hz.id_md_start);
    assign stall_s       = (lu_s || hl_s) && !hz.ex_branch_taken;
    // A wrong-path or stalled MULT/DIV must not launch the unit.
    assign md_start_ok_s = hz.id_md_start && !stall_s && !hz.ex_branch_taken;
    assign flush_evt_s   = hz.ex_branch_taken || (hz.id_jump && !stall_s);

    md_sequencer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_seq (
        .clk       (clk),
        .reset     (reset),
        .start_i   (md_start_ok_s),
        .md_go_o   (md_go_s),
        .md_busy_o (md_busy_s)
    );

    // Priority mux for pipeline-register controls.
    always_comb begin
        hz.pc_wr_en    = 1'b1;
        hz.if_id_wr_en = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_wr_en = 1'b1;
        hz.id_ex_flush = 1'b0;
        if (!reset) begin
            hz.pc_wr_en    = 1'b0;
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (hz.ex_branch_taken) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (stall_s) begin
            hz.pc_wr_en    = 1'b0;
            hz.if_id_wr_en = 1'b0;
            hz.id_ex_flush = 1'b1;
        end else if (hz.id_jump) begin
            hz.if_id_flush = 1'b1;
        end else begin
            hz.if_id_flush = 1'b0;
        end
    end

    // Saturating next values for the perf counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_evt_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.md_go        = md_go_s;
    assign hz.md_busy      = md_busy_s;
    assign hz.stall_cycles = stall_cnt_q;
    assign hz.flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-stamp reference model.
module tb_hazard_ctrl;

    localparam int L   = 4;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       jmp;
        logic       mds;
        logic       hilo;
        logic       mrd;
        logic [4:0] wa;
        logic       br;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hif ();

    hazard_ctrl #(
        .MD_LATENCY (L),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int go_cyc    = -1000;
    int m_stall   = 0;
    int m_flush   = 0;
    bit cnt_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic rst, input logic [4:0] rs, input logic urs,
                                 input logic [4:0] rt, input logic urt, input logic jmp,
                                 input logic mds, input logic hilo, input logic mrd,
                                 input logic [4:0] wa, input logic br);
        stim_t s;
        s.rst = rst; s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt; s.jmp = jmp;
        s.mds = mds; s.hilo = hilo; s.mrd = mrd; s.wa = wa; s.br = br;
        return s;
    endfunction

    task automatic run_cycle(input stim_t s);
        bit busy, lu, hl, stall, go;
        logic [4:0] exp_ctl;
        @(negedge clk);
        reset               = s.rst;
        hif.id_rs_addr      = s.rs;
        hif.id_uses_rs      = s.urs;
        hif.id_rt_addr      = s.rt;
        hif.id_uses_rt      = s.urt;
        hif.id_jump         = s.jmp;
        hif.id_md_start     = s.mds;
        hif.id_hilo_access  = s.hilo;
        hif.ex_MemRead      = s.mrd;
        hif.ex_write_addr   = s.wa;
        hif.ex_branch_taken = s.br;
        #1;
        // Unit is busy strictly between the md_go cycle and md_go+L.
        busy  = s.rst && (cyc > go_cyc) && (cyc < go_cyc + L);
        lu    = s.mrd && (s.wa != 5'd0) &&
                ((s.urs && s.rs == s.wa) || (s.urt && s.rt == s.wa));
        hl    = busy && (s.hilo || s.mds);
        stall = (lu || hl) && !s.br;
        go    = s.rst && !busy && s.mds && !stall && !s.br;
        if (!s.rst)      exp_ctl = 5'b01111;
        else if (s.br)   exp_ctl = 5'b11111;
        else if (stall)  exp_ctl = 5'b00011;
        else if (s.jmp)  exp_ctl = 5'b11110;
        else             exp_ctl = 5'b11010;
        check_eq("ctl{pc,ifwr,iffl,idwr,idfl}",
                 {27'd0, hif.pc_wr_en, hif.if_id_wr_en, hif.if_id_flush,
                  hif.id_ex_wr_en, hif.id_ex_flush}, {27'd0, exp_ctl});
        check_eq("md_go", {31'd0, hif.md_go}, {31'd0, go});
        check_eq("md_busy", {31'd0, hif.md_busy}, {31'd0, busy});
        if (cnt_valid) begin
            check_eq("stall_cycles", {24'd0, hif.stall_cycles}, 32'(m_stall));
            check_eq("flush_events", {24'd0, hif.flush_events}, 32'(m_flush));
        end
        @(posedge clk);
        if (!s.rst) begin
            go_cyc    = -1000;
            m_stall   = 0;
            m_flush   = 0;
            cnt_valid = 1'b1;
        end else begin
            if (go) go_cyc = cyc;
            if (stall && m_stall < SAT) m_stall++;
            if ((s.br || (s.jmp && !stall)) && m_flush < SAT) m_flush++;
        end
        cyc++;
    endtask

    initial begin
        stim_t idle;
        stim_t r;
        idle = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        // Reset
        run_cycle(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
        run_cycle(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
        run_cycle(idle);
        // Load-use then release
        run_cycle(mk(1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0));
        run_cycle(mk(1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0));
        // No false hazards
        run_cycle(mk(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0));
        run_cycle(mk(1'b1, 5'd1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0));
        // Branch beats load-use
        run_cycle(mk(1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1));
        // MULT then MFHI waits out the latency
        run_cycle(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0));
        for (int i = 0; i < 4; i++)
            run_cycle(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0));
        // Back-to-back MULT
        run_cycle(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0));
        for (int i = 0; i < 4; i++)
            run_cycle(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0));
        for (int i = 0; i < 4; i++) run_cycle(idle);
        // Branch with MULT start: no md_go
        run_cycle(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1));
        // Reset mid-BUSY, then MFLO without stall
        run_cycle(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0));
        run_cycle(idle);
        run_cycle(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
        run_cycle(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0));
        // Jump held by a load-use stall, counted once
        run_cycle(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0));
        run_cycle(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0));
        // Random traffic; small register range keeps hazards frequent
        for (int i = 0; i < 4000; i++) begin
            r = mk(($urandom_range(0, 999) != 0),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 20),
                   ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 40),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 12));
            run_cycle(r);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
